hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard controller for the 5-stage MIPS core; it is the stall/flush side of hazard resolution, complementing the bypass path. It keeps its own shadow of the ID/EX destination tag and detects load-use hazards that bypassing cannot cover. It freezes the whole pipeline while a multi-cycle data-memory access is outstanding, and flushes IF/ID and ID/EX on a taken branch. It also keeps a saturating stall-cycle counter and a sticky memory-timeout flag.

## Interface
- MEM_TIMEOUT, 64: consecutive memory-wait cycles after which mem_timeout_o is set (range 1..255).
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- id_valid_i  in  1  ID stage holds a real instruction.
- id_rs_i / id_rt_i  in  5 each  source register numbers of the ID instruction.
- id_rs_used_i / id_rt_used_i  in  1 each  the instruction actually reads rs / rt.
- id_regwrite_i  in  1  the ID instruction writes a register.
- id_memread_i  in  1  the ID instruction is a load.
- id_dst_i  in  5  destination register of the ID instruction (already muxed rt/rd).
- branch_taken_i  in  1  the branch in EX resolved taken this cycle.
- mem_access_i  in  1  the instruction in MEM is a load or a store.
- dmem_ready_i  in  1  data memory completes the MEM access this cycle.
- pc_write_o  out  1  PC may update.
- ifid_write_o  out  1  IF/ID register may load.
- ifid_flush_o  out  1  IF/ID loads a NOP.
- idex_bubble_o  out  1  ID/EX loads a NOP (control bits zero).
- pipe_hold_o  out  1  ID/EX, EX/MEM and MEM/WB hold their contents.
- stall_cnt_o  out  16  saturating count of stall cycles.
- mem_timeout_o  out  1  sticky: a memory wait reached MEM_TIMEOUT.

## Operation
- Shadow register: ex_dst (5 b), ex_regwrite, ex_memread. These mirror what ID/EX holds.
- Derived signals:
  - hold = mem_access_i & ~dmem_ready_i.
  - luse = id_valid_i & ex_memread & ex_regwrite & (ex_dst != 0) & ((id_rs_used_i & id_rs_i == ex_dst) | (id_rt_used_i & id_rt_i == ex_dst)).
- Output priority (combinational, outside reset):
  1. hold: pipe_hold_o=1, pc_write_o=0, ifid_write_o=0, ifid_flush_o=0, idex_bubble_o=0. branch_taken_i and luse are ignored; the branch stays in EX and re-asserts.
  2. branch_taken_i: pc_write_o=1, ifid_write_o=1, ifid_flush_o=1, idex_bubble_o=1.
  3. luse: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, ifid_flush_o=0.
  4. Otherwise: pc_write_o=1, ifid_write_o=1, all other outputs 0.
- Shadow update at each edge:
  - hold: shadow unchanged.
  - idex_bubble_o or ~id_valid_i: shadow cleared.
  - Otherwise: shadow loads id_dst_i, id_regwrite_i and id_memread_i.
- Register $0 never causes a stall.
- FSM states:
  - RUN: moves to MEM_WAIT when hold=1, and wait_cnt becomes 1.
  - MEM_WAIT: each further hold cycle increments wait_cnt (8 b, saturating). Returns to RUN when hold=0, and wait_cnt is cleared.
- mem_timeout_o sets on the edge where wait_cnt reaches MEM_TIMEOUT. It stays set until reset.
- stall_cnt_o increments on every edge where hold or (luse & ~branch_taken_i) is true. It saturates at 16'hFFFF. Branch flush cycles are not counted.

## Timing
- Reset (rst_i=0, asynchronous):
  - shadow cleared, FSM=RUN, wait_cnt=0, stall_cnt_o=0, mem_timeout_o=0.
  - Outputs forced to pc_write_o=0, ifid_write_o=0, ifid_flush_o=1, idex_bubble_o=1, pipe_hold_o=0.
  - Reset in MEM_WAIT abandons the wait.
- Normal outputs start in the first cycle after rst_i rises.
- Load-use costs exactly 1 bubble. In the next cycle the shadow is cleared, so luse=0 and the instruction issues.
- A taken branch costs 2 squashed instructions. Its outputs are same-cycle with branch_taken_i.
- hold is same-cycle with the inputs. The pipeline resumes in the cycle in which dmem_ready_i=1.
- A load-use hazard that coincides with a memory hold is re-evaluated once hold drops. The shadow is preserved, so the bubble still occurs.

## Test plan
- Load-use: lw $3 shadowed in EX, ID add uses rs=$3 -> one cycle with pc_write_o=0 and idex_bubble_o=1; stall_cnt_o goes 0->1; next cycle all normal.
- $0 and unused source: load with dst=$0, or ID uses rs=$3 with id_rs_used_i=0 -> no bubble, stall_cnt_o stays 0.
- Taken branch with a load-use pending: branch_taken_i=1 and luse=1 -> ifid_flush_o=1, idex_bubble_o=1, pc_write_o=1, stall_cnt_o unchanged.
- Memory wait: mem_access_i=1 with dmem_ready_i=0 for 3 cycles, then 1 -> pipe_hold_o=1 for 3 cycles, FSM returns to RUN, stall_cnt_o=3, no timeout.
- Timeout with MEM_TIMEOUT=4: hold for 6 cycles -> mem_timeout_o rises after the 4th edge and stays 1 after the wait ends.
- Reset mid-wait: rst_i low during MEM_WAIT -> immediately stall_cnt_o=0, mem_timeout_o=0, ifid_flush_o=1, idex_bubble_o=1; after release, FSM=RUN.

Source files
------------

// File: rtl/hazard_unit.sv
// Stall/flush controller for the 5-stage MIPS pipeline: load-use bubbles, memory-wait freeze,
// branch squash, plus a saturating stall counter and a sticky memory-timeout flag.
module hazard_unit #(
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        id_valid_i,
    input  logic [4:0]  id_rs_i,
    input  logic [4:0]  id_rt_i,
    input  logic        id_rs_used_i,
    input  logic        id_rt_used_i,
    input  logic        id_regwrite_i,
    input  logic        id_memread_i,
    input  logic [4:0]  id_dst_i,
    input  logic        branch_taken_i,
    input  logic        mem_access_i,
    input  logic        dmem_ready_i,
    output logic        pc_write_o,
    output logic        ifid_write_o,
    output logic        ifid_flush_o,
    output logic        idex_bubble_o,
    output logic        pipe_hold_o,
    output logic [15:0] stall_cnt_o,
    output logic        mem_timeout_o
);

    localparam logic [7:0] TimeoutCnt = 8'(MEM_TIMEOUT);

    typedef enum logic {StRun, StMemWait} state_e;

    state_e      state_q;
    logic [7:0]  wait_cnt_q;
    logic        mem_timeout_q;
    logic [15:0] stall_cnt_q;
    logic [4:0]  ex_dst_q;
    logic        ex_regwrite_q;
    logic        ex_memread_q;

    logic hold;
    logic luse;
    logic rs_hit;
    logic rt_hit;
    logic count_en;

    assign hold   = mem_access_i & ~dmem_ready_i;
    assign rs_hit = id_rs_used_i & (id_rs_i == ex_dst_q);
    assign rt_hit = id_rt_used_i & (id_rt_i == ex_dst_q);
    assign luse   = id_valid_i & ex_memread_q & ex_regwrite_q & (ex_dst_q != 5'd0)
                  & (rs_hit | rt_hit);
    // Branch flush already removes the dependent instruction, so it is not a stall.
    assign count_en = hold | (luse & ~branch_taken_i);

    always_comb begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        pipe_hold_o   = 1'b0;
        if (!rst_i) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            ifid_flush_o  = 1'b1;
            idex_bubble_o = 1'b1;
        end else if (hold) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            pipe_hold_o  = 1'b1;
        end else if (branch_taken_i) begin
            ifid_flush_o  = 1'b1;
            idex_bubble_o = 1'b1;
        end else if (luse) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
        end
    end

    // Shadow of the ID/EX destination; frozen with the pipeline during a memory hold.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_dst_q      <= 5'd0;
            ex_regwrite_q <= 1'b0;
            ex_memread_q  <= 1'b0;
        end else if (!hold) begin
            if (idex_bubble_o || !id_valid_i) begin
                ex_dst_q      <= 5'd0;
                ex_regwrite_q <= 1'b0;
                ex_memread_q  <= 1'b0;
            end else begin
                ex_dst_q      <= id_dst_i;
                ex_regwrite_q <= id_regwrite_i;
                ex_memread_q  <= id_memread_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= 16'd0;
        end else if (count_en && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q       <= StRun;
            wait_cnt_q    <= 8'd0;
            mem_timeout_q <= 1'b0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (hold) begin
                        state_q    <= StMemWait;
                        wait_cnt_q <= 8'd1;
                        if (TimeoutCnt == 8'd1) mem_timeout_q <= 1'b1;
                    end
                end
                StMemWait: begin
                    if (hold) begin
                        if (wait_cnt_q != 8'hFF) wait_cnt_q <= wait_cnt_q + 8'd1;
                        if (wait_cnt_q + 8'd1 == TimeoutCnt) mem_timeout_q <= 1'b1;
                    end else begin
                        state_q    <= StRun;
                        wait_cnt_q <= 8'd0;
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

    assign stall_cnt_o   = stall_cnt_q;
    assign mem_timeout_o = mem_timeout_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed vectors queue expected outputs, a monitor compares.
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_dst;
    logic        id_rs_used, id_rt_used, id_regwrite, id_memread;
    logic        branch_taken, mem_access, dmem_ready;
    logic        pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold;
    logic [15:0] stall_cnt;
    logic        mem_timeout;

    always #5 clk = ~clk;

    hazard_unit #(.MEM_TIMEOUT(4)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .id_valid_i     (id_valid),
        .id_rs_i        (id_rs),
        .id_rt_i        (id_rt),
        .id_rs_used_i   (id_rs_used),
        .id_rt_used_i   (id_rt_used),
        .id_regwrite_i  (id_regwrite),
        .id_memread_i   (id_memread),
        .id_dst_i       (id_dst),
        .branch_taken_i (branch_taken),
        .mem_access_i   (mem_access),
        .dmem_ready_i   (dmem_ready),
        .pc_write_o     (pc_write),
        .ifid_write_o   (ifid_write),
        .ifid_flush_o   (ifid_flush),
        .idex_bubble_o  (idex_bubble),
        .pipe_hold_o    (pipe_hold),
        .stall_cnt_o    (stall_cnt),
        .mem_timeout_o  (mem_timeout)
    );

    typedef struct packed {
        logic [4:0]  ctrl;  // {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold}
        logic [15:0] cnt;
        logic        to;
    } exp_t;

    localparam logic [4:0] NORM = 5'b11000;
    localparam logic [4:0] RSTV = 5'b00110;
    localparam logic [4:0] LU   = 5'b00010;
    localparam logic [4:0] BR   = 5'b11110;
    localparam logic [4:0] HLD  = 5'b00001;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    task automatic vec(input string nm, input logic r, v, input logic [4:0] rs, rt,
                       input logic rsu, rtu, rw, mr, input logic [4:0] dst,
                       input logic br, ma, rdy, input logic [4:0] ctrl,
                       input logic [15:0] cnt, input logic to);
        exp_t e;
        @(negedge clk);
        rst = r; id_valid = v; id_rs = rs; id_rt = rt; id_rs_used = rsu; id_rt_used = rtu;
        id_regwrite = rw; id_memread = mr; id_dst = dst;
        branch_taken = br; mem_access = ma; dmem_ready = rdy;
        e.ctrl = ctrl; e.cnt = cnt; e.to = to;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    initial begin : monitor
        exp_t  e;
        exp_t  act;
        string nm;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                act.ctrl = {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold};
                act.cnt  = stall_cnt;
                act.to   = mem_timeout;
                n_vec++;
                if (act !== e) begin
                    n_err++;
                    $display("FAIL %s: got ctrl=%b cnt=%0d to=%b, want ctrl=%b cnt=%0d to=%b",
                             nm, act.ctrl, act.cnt, act.to, e.ctrl, e.cnt, e.to);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_rs_used = 1'b0;
        id_rt_used = 1'b0; id_regwrite = 1'b0; id_memread = 1'b0; id_dst = 5'd0;
        branch_taken = 1'b0; mem_access = 1'b0; dmem_ready = 1'b0;

        //  name            r  v  rs  rt rsu rtu rw mr dst br ma rdy ctrl cnt to
        vec("reset",        0, 0, 0,  0, 0,  0,  0, 0, 0,  0, 0, 0,  RSTV, 0,  0);
        vec("idle",         1, 0, 0,  0, 0,  0,  0, 0, 0,  0, 0, 0,  NORM, 0,  0);
        vec("lw3_in_id",    1, 1, 1,  2, 1,  1,  1, 1, 3,  0, 0, 0,  NORM, 0,  0);
        vec("luse_rs",      1, 1, 3,  4, 1,  1,  1, 0, 5,  0, 0, 0,  LU,   0,  0);
        vec("issue_rs",     1, 1, 3,  4, 1,  1,  1, 0, 5,  0, 0, 0,  NORM, 1,  0);
        vec("lw0_in_id",    1, 1, 5,  0, 1,  0,  1, 1, 0,  0, 0, 0,  NORM, 1,  0);
        vec("use_r0",       1, 1, 0,  0, 1,  1,  1, 1, 3,  0, 0, 0,  NORM, 1,  0);
        vec("rs_unused",    1, 1, 3,  7, 0,  1,  1, 0, 8,  0, 0, 0,  NORM, 1,  0);
        vec("lw9_in_id",    1, 1, 1,  2, 1,  1,  1, 1, 9,  0, 0, 0,  NORM, 1,  0);
        vec("br_over_luse", 1, 1, 1,  9, 1,  1,  1, 0, 10, 1, 0, 0,  BR,   1,  0);
        vec("lw9_again",    1, 1, 0,  0, 0,  0,  1, 1, 9,  0, 0, 0,  NORM, 1,  0);
        vec("luse_rt",      1, 1, 2,  9, 1,  1,  1, 0, 10, 0, 0, 0,  LU,   1,  0);
        vec("issue_rt",     1, 1, 2,  9, 1,  1,  1, 0, 10, 0, 0, 0,  NORM, 2,  0);
        vec("lw11_in_id",   1, 1, 0,  0, 0,  0,  1, 1, 11, 0, 0, 0,  NORM, 2,  0);
        vec("hold1_luse",   1, 1, 11, 0, 1,  0,  1, 0, 12, 1, 1, 0,  HLD,  2,  0);
        vec("hold2",        1, 1, 11, 0, 1,  0,  1, 0, 12, 1, 1, 0,  HLD,  3,  0);
        vec("hold3",        1, 1, 11, 0, 1,  0,  1, 0, 12, 1, 1, 0,  HLD,  4,  0);
        vec("ready_luse",   1, 1, 11, 0, 1,  0,  1, 0, 12, 0, 1, 1,  LU,   5,  0);
        vec("resume",       1, 1, 11, 0, 1,  0,  1, 0, 12, 0, 0, 0,  NORM, 6,  0);
        vec("to_hold1",     1, 0, 0,  0, 0,  0,  0, 0, 0,  0, 1, 0,  HLD,  6,  0);
        vec("to_hold2",     1, 0, 0,  0, 0,  0,  0, 0, 0,  0, 1, 0,  HLD,  7,  0);
        vec("to_hold3",     1, 0, 0,  0, 0,  0,  0, 0, 0,  0, 1, 0,  HLD,  8,  0);
        vec("to_hold4",     1, 0, 0,  0, 0,  0,  0, 0, 0,  0, 1, 0,  HLD,  9,  0);
        vec("to_hold5",     1, 0, 0,  0, 0,  0,  0, 0, 0,  0, 1, 0,  HLD,  10, 1);
        vec("to_hold6",     1, 0, 0,  0, 0,  0,  0, 0, 0,  0, 1, 0,  HLD,  11, 1);
        vec("to_ready",     1, 0, 0,  0, 0,  0,  0, 0, 0,  0, 1, 1,  NORM, 12, 1);
        vec("to_sticky",    1, 0, 0,  0, 0,  0,  0, 0, 0,  0, 0, 0,  NORM, 12, 1);
        vec("pre_rst_hold", 1, 0, 0,  0, 0,  0,  0, 0, 0,  0, 1, 0,  HLD,  12, 1);
        vec("rst_mid_wait", 0, 0, 0,  0, 0,  0,  0, 0, 0,  0, 1, 0,  RSTV, 0,  0);
        vec("post_rst",     1, 0, 0,  0, 0,  0,  0, 0, 0,  0, 0, 0,  NORM, 0,  0);
        vec("fresh_hold1",  1, 0, 0,  0, 0,  0,  0, 0, 0,  0, 1, 0,  HLD,  0,  0);
        vec("fresh_hold2",  1, 0, 0,  0, 0,  0,  0, 0, 0,  0, 1, 0,  HLD,  1,  0);
        vec("fresh_hold3",  1, 0, 0,  0, 0,  0,  0, 0, 0,  0, 1, 0,  HLD,  2,  0);
        vec("fresh_ready",  1, 0, 0,  0, 0,  0,  0, 0, 0,  0, 1, 1,  NORM, 3,  0);

        repeat (2) @(negedge clk);
        #5;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
